// File: rtl/mult_div_unit_pkg.sv
// Shared MDU op codes and op-class helpers for the multiply/divide unit.
// Op codes 7..10 (multiply-accumulate) are only honoured when MDU_MADD_EN is defined.
package mult_div_unit_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] mduNone  = 4'd0;
  localparam logic [OP_W-1:0] mduMult  = 4'd1;
  localparam logic [OP_W-1:0] mduMultu = 4'd2;
  localparam logic [OP_W-1:0] mduDiv   = 4'd3;
  localparam logic [OP_W-1:0] mduDivu  = 4'd4;
  localparam logic [OP_W-1:0] mduMthi  = 4'd5;
  localparam logic [OP_W-1:0] mduMtlo  = 4'd6;
  localparam logic [OP_W-1:0] mduMadd  = 4'd7;
  localparam logic [OP_W-1:0] mduMaddu = 4'd8;
  localparam logic [OP_W-1:0] mduMsub  = 4'd9;
  localparam logic [OP_W-1:0] mduMsubu = 4'd10;

  // Two's-complement interpretation of operands.
  function automatic logic op_is_signed(input logic [OP_W-1:0] code);
    return (code == mduMult) || (code == mduDiv) || (code == mduMadd) || (code == mduMsub);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] code);
    return (code == mduDiv) || (code == mduDivu);
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, valid pulses after WIDTH iterations.
// A new start restarts the core regardless of any division in progress.
module mdu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;

  // Partial remainder is always below the divisor, so bit WIDTH of diff is a clean borrow flag.
  always_comb begin
    shifted_c = {rem, quo[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        quo <= dividend;
        rem <= '0;
        dvs <= divisor;
        cnt <= CNT_W'(WIDTH);
        run <= 1'b1;
      end else if (run) begin
        if (!diff_c[WIDTH]) begin
          rem <= diff_c[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted_c[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          run   <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = (MUL_CYCLES < 2) ? 1 : $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] hi_d, lo_d, a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             busy_d, done_d;

  logic             div_start_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             div_valid;
  logic [W2-1:0]    a_ext_c, b_ext_c, prod_c, mul_res_c;
  logic [WIDTH-1:0] div_hi_c, div_lo_c;

  function automatic logic is_mul_op(input logic [3:0] code);
`ifdef MDU_MADD_EN
    return (code == mduMult) || (code == mduMultu) || (code == mduMadd) ||
           (code == mduMaddu) || (code == mduMsub) || (code == mduMsubu);
`else
    return (code == mduMult) || (code == mduMultu);
`endif
  endfunction

  // Divider sees magnitudes; sign fixup happens at writeback from the latched operands.
  always_comb begin
    a_mag_c = (op_is_signed(op) && A[WIDTH-1]) ? -A : A;
    b_mag_c = (op_is_signed(op) && B[WIDTH-1]) ? -B : B;
  end

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start_c),
    .dividend  (a_mag_c),
    .divisor   (b_mag_c),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Full-width product; truncation to 2*WIDTH gives the signed result for sign-extended operands.
  always_comb begin
    a_ext_c   = op_is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext_c   = op_is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod_c    = a_ext_c * b_ext_c;
    mul_res_c = prod_c;
`ifdef MDU_MADD_EN
    if ((op_q == mduMadd) || (op_q == mduMaddu)) begin
      mul_res_c = {hi, lo} + prod_c;
    end else if ((op_q == mduMsub) || (op_q == mduMsubu)) begin
      mul_res_c = {hi, lo} - prod_c;
    end
`endif
  end

  always_comb begin
    div_lo_c = (op_is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quo : div_quo;
    div_hi_c = (op_is_signed(op_q) && a_q[WIDTH-1]) ? -div_rem : div_rem;
    if (b_q == '0) begin
      div_lo_c = '1;
      div_hi_c = a_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= mduNone;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      hi    <= hi_d;
      lo    <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    hi_d        = hi;
    lo_d        = lo;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    busy_d      = busy;
    done_d      = 1'b0;
    div_start_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !cancel) begin
          if (op == mduMthi) begin
            hi_d = A;
          end else if (op == mduMtlo) begin
            lo_d = A;
          end else if (is_mul_op(op)) begin
            state_d = S_MUL;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(MUL_CYCLES);
            a_d     = A;
            b_d     = B;
            op_d    = op;
          end else if (op_is_div(op)) begin
            state_d     = S_DIV;
            busy_d      = 1'b1;
            div_start_c = 1'b1;
            a_d         = A;
            b_d         = B;
            op_d        = op;
          end
        end
      end

      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(1)) begin
          {hi_d, lo_d} = mul_res_c;
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (div_valid) begin
          hi_d    = div_hi_c;
          lo_d    = div_lo_c;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32, MUL_CYCLES=4) against an arithmetic reference model.
// Define MDU_MADD_EN for both bench and RTL to exercise the accumulate ops.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int          MUL_LAT = 4;
  localparam int          DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [3:0] o, input logic [31:0] a, b,
                                          input logic [31:0] acc_hi, acc_lo);
    longint sp;
    logic [63:0] p, acc;
    if (o == mduMult || o == mduMadd || o == mduMsub) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p  = 64'(sp);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    acc = {acc_hi, acc_lo};
    if (o == mduMadd || o == mduMaddu) return acc + p;
    if (o == mduMsub || o == mduMsubu) return acc - p;
    return p;
  endfunction

  function automatic logic [63:0] ref_div(input logic [3:0] o, input logic [31:0] a, b);
    longint x, y, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == mduDiv) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    q  = x / y;
    r  = x % y;
    qv = 64'(q);
    rv = 64'(r);
    return {rv[31:0], qv[31:0]};
  endfunction

  // Issue one mul/div op and follow it to completion; poke fires a stray start while busy.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, b, input bit poke);
    logic [63:0] expv;
    int          cyc;
    int          lat;
    logic        hold_bad;
    lat  = op_is_div(o) ? DIV_LAT : MUL_LAT;
    expv = op_is_div(o) ? ref_div(o, a, b) : ref_mul(o, a, b, m_hi, m_lo);
    hold_bad = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = mduNone;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (done !== 1'b0 || hi !== m_hi || lo !== m_lo) hold_bad = 1'b1;
      if (poke && cyc == 1) begin
        start = 1'b1; op = mduMthi; A = 32'hDEAD_BEEF; B = 32'h0;
      end else begin
        start = 1'b0; op = mduNone; A = $urandom; B = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; op = mduNone;
    check("hold_while_busy", 64'(hold_bad), 64'(0));
    check("latency", 64'(cyc), 64'(lat));
    check("done_pulse", 64'(done), 64'(1));
    check("hi", 64'(hi), 64'(expv[63:32]));
    check("lo", 64'(lo), 64'(expv[31:0]));
    m_hi = expv[63:32];
    m_lo = expv[31:0];
    @(posedge clk); #1;
    check("done_clear", {62'b0, done, busy}, 64'(0));
  endtask

  task automatic move_to(input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; A = a;
    @(posedge clk); #1;
    start = 1'b0; op = mduNone;
    if (o == mduMthi) m_hi = a;
    else m_lo = a;
    check("move_busy", 64'(busy), 64'(0));
    check("move_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;

    reset_n = 1'b0; start = 1'b0; op = mduNone; A = '0; B = '0; cancel = 1'b0;
    #12;
    check("reset_state", {30'b0, busy, done, hi, lo}, 64'(0));
    @(negedge clk); reset_n = 1'b1;

    run_op(mduMult, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(mduMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(mduDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(mduDivu, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("divu_const", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
    run_op(mduDiv, 32'd5, 32'd0, 1'b0);
    check("div_by_zero", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    run_op(mduDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);

    // Cancel a divide mid-flight; the abandoned result must never land.
    move_to(mduMthi, 32'h0000_1234);
    move_to(mduMtlo, 32'h0000_0077);
    @(negedge clk);
    start = 1'b1; op = mduDiv; A = 32'd1000; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = mduNone;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'(0));
    check("cancel_done", 64'(done), 64'(0));
    check("cancel_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (DIV_LAT + 2) @(posedge clk);
    #1 check("cancel_stale", {30'b0, busy, done, hi, lo}, {32'b0, m_hi, m_lo});

    // Cancel coinciding with the multiply write edge.
    @(negedge clk);
    start = 1'b1; op = mduMult; A = 32'd3; B = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; op = mduNone;
    repeat (MUL_LAT - 1) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_write_edge", {30'b0, busy, done, hi, lo}, {32'b0, m_hi, m_lo});

    // Cancel alongside start in IDLE discards even MTHI.
    @(negedge clk);
    start = 1'b1; op = mduMthi; A = 32'h0000_0999; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = mduNone; cancel = 1'b0;
    check("cancel_idle", {31'b0, busy, hi}, {32'b0, m_hi});

    // mduNone with start does nothing.
    @(negedge clk);
    start = 1'b1; op = mduNone; A = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0;
    check("op_none", {30'b0, busy, done, hi, lo}, {32'b0, m_hi, m_lo});

`ifdef MDU_MADD_EN
    move_to(mduMthi, 32'd0);
    move_to(mduMtlo, 32'd5);
    run_op(mduMadd, 32'd2, 32'd3, 1'b0);
    check("madd_const", {hi, lo}, 64'h0000_0000_0000_000B);
    run_op(mduMsub, 32'd4, 32'd4, 1'b0);
    run_op(mduMaddu, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0);
    run_op(mduMsubu, 32'h8000_0000, 32'h0000_0003, 1'b0);
`else
    @(negedge clk);
    start = 1'b1; op = mduMadd; A = 32'd2; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = mduNone;
    check("madd_disabled", {30'b0, busy, done, hi, lo}, {32'b0, m_hi, m_lo});
`endif

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       r_op = mduMult;
        1:       r_op = mduMultu;
        2:       r_op = mduDiv;
        default: r_op = mduDivu;
      endcase
      r_a = $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, i[0]);
    end

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = mduMult; A = 32'd11; B = 32'd13;
    @(posedge clk); #1;
    start = 1'b0; op = mduNone;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1 check("reset_mid_mult", {30'b0, busy, done, hi, lo}, 64'(0));
    m_hi = '0; m_lo = '0;
    @(negedge clk); reset_n = 1'b1;
    repeat (MUL_LAT + 1) @(posedge clk);
    #1 check("reset_no_result", {30'b0, busy, done, hi, lo}, 64'(0));
    run_op(mduMult, 32'h0001_0000, 32'h0001_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
